systolic_tile_sequencer: RTL
============================

# systolic_tile_sequencer

Sequencer for the 8x8 PE systolic cluster. It accepts a tile command with reduction length K and streams K activation vectors and K weight vectors from two single-port read buffers into the cluster with per-lane diagonal skew. It marks each lane's last element on the cluster's `done` bus, waits for all 64 PE completion flags, and then holds the cluster's results stable until the consumer acknowledges them.

## Interface
Parameters:
- `K_MAX`, 256: maximum reduction length; `k_len` width is clog2(K_MAX)+1.
- `ADDR_W`, 8: buffer address width; must satisfy 2^ADDR_W >= K_MAX.
- `DRAIN_MAX`, 32: cycle limit in DRAIN before timeout.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  tile command strobe; accepted only in IDLE.
- `k_len`  in  9  reduction length, legal range 1..K_MAX; sampled with `start`.
- `busy`  out  1  high in every state except IDLE.
- `act_rd`, `wgt_rd`  out  1  buffer read enables.
- `act_addr`, `wgt_addr`  out  ADDR_W  read addresses.
- `act_rdata`, `wgt_rdata`  in  128  8 lanes x 16 bit; lane i = bits [16i+15:16i]; valid 1 cycle after the read.
- `arr_en`  out  1  cluster enable; 0 clears the cluster.
- `arr_activations`, `arr_weights`  out  128  skewed lane data to the cluster.
- `arr_done`  out  8  per-row/column last-element marker.
- `arr_output_dones`  in  64  PE completion flags from the cluster.
- `tile_valid`  out  1  results stable and complete.
- `tile_ack`  in  1  consumer has taken the results.
- `err`  out  1  sticky error flag; cleared by the next accepted `start`.

## Operation
States and transitions:
- IDLE -> CLEAR on `start` with `k_len` in 1..K_MAX. If `k_len` is 0 or greater than K_MAX, set `err` and stay in IDLE. A `start` outside IDLE is ignored.
- CLEAR lasts 1 cycle. `arr_en`=0, which clears the cluster accumulators and registers.
- FEED: issue reads at addresses 0..K-1, one per cycle, on both buffers together. Exit after address K-1 is issued.
- DRAIN: no reads are issued; the skew lines flush zeros.
  - Exit to DONE when `arr_output_dones` is all ones and the skew pipeline is empty.
  - If DRAIN_MAX cycles elapse first, set `err` and go to IDLE without asserting `tile_valid`.
- DONE: `tile_valid`=1 until `tile_ack`, then go to IDLE.

Datapath rules:
- `arr_en`=1 in FEED, DRAIN, DONE and IDLE, so results stay readable after ack. `arr_en`=0 only in CLEAR.
- Lane i of both buses is delayed i cycles relative to lane 0. A lane carries 16'h0 when it has no valid element.
- `arr_done[i]`=1 for exactly the cycle in which lane i carries element K-1; otherwise 0.

Reset values: state IDLE; `busy`, `act_rd`, `wgt_rd`, `tile_valid`, `err` = 0; addresses 0; `arr_en`=0; data buses 0; `arr_done`=0; skew registers 0.

Reset asserted mid-operation drops immediately to IDLE with all outputs at their reset values. No partial `tile_valid` is ever produced.

## Timing
All cycles are numbered relative to the `start` acceptance cycle, 0.
- Cycle 1: CLEAR.
- Cycles 2..K+1: reads at addresses 0..K-1.
- Lane i, element j appears on `arr_activations`/`arr_weights` at cycle 3+j+i.
- `arr_done[i]` is high at cycle K+2+i. Lane 7's last element is at cycle K+9.
- DRAIN begins at cycle K+2. The DRAIN_MAX counter starts at DRAIN entry.
- `tile_valid` rises the cycle after the exit condition is met.
- A `tile_ack` high in the same cycle `tile_valid` rises is honoured; the next cycle is IDLE.
- A new `start` is accepted in the first IDLE cycle.

## Structure
- Shared package holds:
  - LANES=8, DATA_W=16, SUM_W=36;
  - the state enum (IDLE, CLEAR, FEED, DRAIN, DONE);
  - the lane slice helper.
- Sub-module `skew_line`: parameterised depth-N delay for one 16-bit lane plus its valid/last bits, instantiated per lane and per operand.
- Top level contains the FSM, address counter and drain timer.

## Test plan
- K=1, act=weights=lane value 1 -> lane i shows 16'h1 only at cycle 3+i; `arr_done[i]` high at cycle 3+i; `tile_valid` asserted after all 64 flags are set.
- K=4, address a holds lane value a+1 -> lane 3 presents 1,2,3,4 at cycles 6..9; `arr_done[3]` high at cycle 9; exactly 4 reads are issued.
- K=256 -> addresses 0..255 are issued without wrap; `arr_done[7]` high at cycle 265.
- `k_len`=0, then `start` -> `err`=1, `busy` stays 0; next legal `start` clears `err`.
- `arr_output_dones` held at 64'h0 -> after 32 DRAIN cycles `err`=1, state IDLE, `tile_valid` never 1.
- `rst_n` low during FEED at cycle 5 -> all outputs take their reset values asynchronously; after release, `start` with K=2 completes normally; `tile_ack` delayed 10 cycles holds `tile_valid` and `arr_en` high throughout.

Source files
------------

// File: rtl/systolic_tile_sequencer_pkg.sv
// Shared definitions for the systolic tile sequencer: lane geometry,
// FSM state encoding and the helper that picks one lane out of a bus.
package systolic_tile_sequencer_pkg;

    localparam int LANES  = 8;
    localparam int DATA_W = 16;
    localparam int SUM_W  = 36;
    localparam int BUS_W  = LANES * DATA_W;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FEED  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Lane i of a packed lane bus lives at bits [16i+15:16i].
    function automatic logic [DATA_W-1:0] lane_slice(input logic [BUS_W-1:0] bus,
                                                     input int unsigned     lane);
        return bus[lane*DATA_W +: DATA_W];
    endfunction

endpackage

// File: rtl/systolic_tile_sequencer_skew_line.sv
// Fixed-depth delay line for one 16-bit lane plus its valid and last-element
// bits. Data is zeroed on entry when not valid so the lane reads 0 between
// elements. o_busy reports any valid element still in flight.
module skew_line
    import systolic_tile_sequencer_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_vld,
    input  logic              i_last,
    output logic [DATA_W-1:0] o_data,
    output logic              o_last,
    output logic              o_busy
);

    logic [DATA_W-1:0] r_data [DEPTH];
    logic [DEPTH-1:0]  r_vld;
    logic [DEPTH-1:0]  r_last;

    // Shift register: stage 0 captures the gated input, later stages follow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < DEPTH; s++) begin
                r_data[s] <= '0;
            end
            r_vld  <= '0;
            r_last <= '0;
        end else begin
            r_data[0] <= i_vld ? i_data : '0;
            r_vld[0]  <= i_vld;
            r_last[0] <= i_vld & i_last;
            for (int s = 1; s < DEPTH; s++) begin
                r_data[s] <= r_data[s-1];
                r_vld[s]  <= r_vld[s-1];
                r_last[s] <= r_last[s-1];
            end
        end
    end

    assign o_data = r_data[DEPTH-1];
    assign o_last = r_last[DEPTH-1];
    assign o_busy = |r_vld;

endmodule

// File: rtl/systolic_tile_sequencer.sv
// Tile sequencer for the 8x8 systolic cluster. Accepts a tile command,
// clears the cluster, streams K activation/weight rows from the read buffers
// with a per-lane diagonal skew, waits for all PE completion flags and holds
// the results valid until the consumer acknowledges them.
module systolic_tile_sequencer
    import systolic_tile_sequencer_pkg::*;
#(
    parameter int K_MAX     = 256,
    parameter int ADDR_W    = 8,
    parameter int DRAIN_MAX = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [$clog2(K_MAX):0]   k_len,
    output logic                     busy,
    output logic                     act_rd,
    output logic                     wgt_rd,
    output logic [ADDR_W-1:0]        act_addr,
    output logic [ADDR_W-1:0]        wgt_addr,
    input  logic [BUS_W-1:0]         act_rdata,
    input  logic [BUS_W-1:0]         wgt_rdata,
    output logic                     arr_en,
    output logic [BUS_W-1:0]         arr_activations,
    output logic [BUS_W-1:0]         arr_weights,
    output logic [LANES-1:0]         arr_done,
    input  logic [LANES*LANES-1:0]   arr_output_dones,
    output logic                     tile_valid,
    input  logic                     tile_ack,
    output logic                     err,
    output logic [2:0]               o_dbg_state
);

    localparam int K_W  = $clog2(K_MAX) + 1;
    localparam int DC_W = $clog2(DRAIN_MAX) + 1;

    state_t            r_state;
    state_t            w_next_state;
    logic [K_W-1:0]    r_k;
    logic [K_W-1:0]    r_cnt;
    logic              r_rd_vld;
    logic              r_rd_last;
    logic [DC_W-1:0]   r_drain_cnt;
    logic              r_err;
    logic              r_arr_en;

    logic              w_start_ok;
    logic              w_last_addr;
    logic              w_pipe_empty;
    logic              w_drain_exit;
    logic              w_drain_timeout;
    logic [LANES-1:0]  w_act_last;
    logic [LANES-1:0]  w_wgt_last;
    logic [LANES-1:0]  w_act_busy;
    logic [LANES-1:0]  w_wgt_busy;

    assign w_start_ok      = start && (k_len != '0) && (k_len <= K_W'(K_MAX));
    assign w_last_addr     = (r_cnt == r_k - 1'b1);
    assign w_pipe_empty    = !r_rd_vld && !(|w_act_busy) && !(|w_wgt_busy);
    assign w_drain_exit    = (&arr_output_dones) && w_pipe_empty;
    assign w_drain_timeout = (r_drain_cnt == DC_W'(DRAIN_MAX - 1));

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and state-decoded outputs. In DRAIN a completed tile wins
    // over a timeout landing in the same cycle.
    always_comb begin
        w_next_state = r_state;
        busy         = 1'b1;
        act_rd       = 1'b0;
        wgt_rd       = 1'b0;
        tile_valid   = 1'b0;
        unique case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (w_start_ok) w_next_state = CLEAR;
            end
            CLEAR: begin
                w_next_state = FEED;
            end
            FEED: begin
                act_rd = 1'b1;
                wgt_rd = 1'b1;
                if (w_last_addr) w_next_state = DRAIN;
            end
            DRAIN: begin
                if (w_drain_exit) begin
                    w_next_state = DONE;
                end else if (w_drain_timeout) begin
                    w_next_state = IDLE;
                end
            end
            DONE: begin
                tile_valid = 1'b1;
                if (tile_ack) w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Tile length captured when a command is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_k <= '0;
        end else if (r_state == IDLE && w_start_ok) begin
            r_k <= k_len;
        end
    end

    // Read address counter: walks 0..K-1 during FEED, parked at 0 otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_state == FEED && !w_last_addr) begin
            r_cnt <= r_cnt + 1'b1;
        end else begin
            r_cnt <= '0;
        end
    end

    // Read data arrives one cycle after the read; track its valid/last flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_vld  <= 1'b0;
            r_rd_last <= 1'b0;
        end else begin
            r_rd_vld  <= (r_state == FEED);
            r_rd_last <= (r_state == FEED) && w_last_addr;
        end
    end

    // Drain timer counts cycles spent in DRAIN from entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drain_cnt <= '0;
        end else if (r_state == DRAIN) begin
            r_drain_cnt <= r_drain_cnt + 1'b1;
        end else begin
            r_drain_cnt <= '0;
        end
    end

    // Sticky error: any start seen in IDLE rewrites it (legal clears, illegal
    // sets); a drain timeout sets it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (r_state == IDLE && start) begin
            r_err <= !w_start_ok;
        end else if (r_state == DRAIN && !w_drain_exit && w_drain_timeout) begin
            r_err <= 1'b1;
        end
    end

    // Cluster enable is registered so it reads 0 in reset; low only in CLEAR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_arr_en <= 1'b0;
        end else begin
            r_arr_en <= (w_next_state != CLEAR);
        end
    end

    // Lane 0 has no skew: gated read data straight to the cluster.
    assign arr_activations[DATA_W-1:0] = r_rd_vld ? lane_slice(act_rdata, 0) : '0;
    assign arr_weights[DATA_W-1:0]     = r_rd_vld ? lane_slice(wgt_rdata, 0) : '0;
    assign w_act_last[0]               = r_rd_last;
    assign w_wgt_last[0]               = r_rd_last;
    assign w_act_busy[0]               = 1'b0;
    assign w_wgt_busy[0]               = 1'b0;

    // Lanes 1..7 are delayed by their lane index.
    for (genvar gi = 1; gi < LANES; gi++) begin : g_lane
        skew_line #(.DEPTH(gi)) u_act_skew (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_data (lane_slice(act_rdata, gi)),
            .i_vld  (r_rd_vld),
            .i_last (r_rd_last),
            .o_data (arr_activations[gi*DATA_W +: DATA_W]),
            .o_last (w_act_last[gi]),
            .o_busy (w_act_busy[gi])
        );
        skew_line #(.DEPTH(gi)) u_wgt_skew (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_data (lane_slice(wgt_rdata, gi)),
            .i_vld  (r_rd_vld),
            .i_last (r_rd_last),
            .o_data (arr_weights[gi*DATA_W +: DATA_W]),
            .o_last (w_wgt_last[gi]),
            .o_busy (w_wgt_busy[gi])
        );
    end

    assign arr_done    = w_act_last & w_wgt_last;
    assign act_addr    = ADDR_W'(r_cnt);
    assign wgt_addr    = ADDR_W'(r_cnt);
    assign arr_en      = r_arr_en;
    assign err         = r_err;
    assign o_dbg_state = r_state;

endmodule
